// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: scheduler FSM state
// encoding, default sample width and saturation-limit helpers.
package synth_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SUM   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Largest / smallest value representable in a w-bit signed sample.
   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings an asynchronous strobe into the local clock domain.
// Ports: i_clk, i_rst_n (sync, active low), i_async in, o_pulse one-cycle out.
module tick_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_pulse
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_pulse;

   // Two flops resolve metastability; the third keeps the previous level
   // for the rising-edge detect, and the pulse itself is registered.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_s1    <= i_async;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_pulse <= r_s2 & ~r_s3;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/voice_scheduler.sv
// Per-sample frame sequencer: requests each enabled voice from the shared
// datapath, sums the signed replies and emits one saturated mixed sample.
// Ports: CLK_50MHZ, RESET_N (sync, active low), CLK_44100HZ async tick,
// VOICE_EN, REQ_VALID/REQ_VOICE/REQ_READY request handshake,
// RESP_VALID/RESP_DATA reply, SAMPLE_OUT/SAMPLE_VALID mix, BUSY,
// sticky OVERRUN/TIMEOUT_ERR and ERR_CLR.
module voice_scheduler
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int TIMEOUT    = 255
) (
   input  logic                          CLK_50MHZ,
   input  logic                          RESET_N,
   input  logic                          CLK_44100HZ,
   input  logic [NUM_VOICES-1:0]         VOICE_EN,
   output logic                          REQ_VALID,
   output logic [$clog2(NUM_VOICES)-1:0] REQ_VOICE,
   input  logic                          REQ_READY,
   input  logic                          RESP_VALID,
   input  logic signed [DATA_W-1:0]      RESP_DATA,
   output logic signed [DATA_W-1:0]      SAMPLE_OUT,
   output logic                          SAMPLE_VALID,
   output logic                          BUSY,
   output logic                          OVERRUN,
   output logic                          TIMEOUT_ERR,
   input  logic                          ERR_CLR
);

   localparam int SW    = $clog2(NUM_VOICES);
   localparam int ACC_W = DATA_W + SW;
   localparam int CW    = $clog2(TIMEOUT + 1);

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(DATA_W));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(DATA_W));

   logic [2:0]               r_state;
   logic [SW-1:0]            r_slot;
   logic [NUM_VOICES-1:0]    r_en;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [DATA_W-1:0] r_val;
   logic [CW-1:0]            r_cnt;
   logic signed [DATA_W-1:0] r_sample;
   logic                     r_ovr;
   logic                     r_to;

   logic                     w_tick;
   logic [2:0]               w_state_nxt;
   logic signed [ACC_W-1:0]  w_acc_nxt;
   logic signed [DATA_W-1:0] w_sat;
   logic                     w_last;
   logic                     w_to_set;
   logic                     w_timeout;

   tick_sync u_tick_sync (
      .i_clk   (CLK_50MHZ),
      .i_rst_n (RESET_N),
      .i_async (CLK_44100HZ),
      .o_pulse (w_tick)
   );

   assign w_last    = (r_slot == SW'(NUM_VOICES - 1));
   assign w_timeout = (r_cnt == CW'(TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_to_set    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               w_acc_nxt   = '0;
               w_state_nxt = (VOICE_EN == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!r_en[r_slot]) begin
               w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
            end else if (REQ_READY) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A reply arriving on the timeout cycle still counts.
            if (RESP_VALID) begin
               w_state_nxt = ST_SUM;
            end else if (w_timeout) begin
               w_state_nxt = ST_SUM;
               w_to_set    = 1'b1;
            end
         end
         ST_SUM: begin
            w_acc_nxt   = r_acc + {{SW{r_val[DATA_W-1]}}, r_val};
            w_state_nxt = w_last ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Clamp the final accumulator to the sample range.
   always_comb begin
      if (w_acc_nxt > SAT_HI) begin
         w_sat = SAT_HI[DATA_W-1:0];
      end else if (w_acc_nxt < SAT_LO) begin
         w_sat = SAT_LO[DATA_W-1:0];
      end else begin
         w_sat = w_acc_nxt[DATA_W-1:0];
      end
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (!RESET_N) begin
         r_state  <= ST_IDLE;
         r_slot   <= '0;
         r_en     <= '0;
         r_acc    <= '0;
         r_val    <= '0;
         r_cnt    <= '0;
         r_sample <= '0;
         r_ovr    <= 1'b0;
         r_to     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;

         unique case (r_state)
            ST_IDLE: begin
               if (w_tick) begin
                  r_en   <= VOICE_EN;
                  r_slot <= '0;
               end
            end
            ST_ISSUE: begin
               if (!r_en[r_slot]) begin
                  if (!w_last) begin
                     r_slot <= r_slot + 1'b1;
                  end
               end else if (REQ_READY) begin
                  r_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (RESP_VALID) begin
                  r_val <= RESP_DATA;
               end else if (w_timeout) begin
                  r_val <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SUM: begin
               if (!w_last) begin
                  r_slot <= r_slot + 1'b1;
               end
            end
            default: begin
            end
         endcase

         // Output register loads on the edge entering DONE, so it is
         // already valid during the SAMPLE_VALID cycle.
         if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
            r_sample <= w_sat;
         end

         if (w_tick && r_state != ST_IDLE) begin
            r_ovr <= 1'b1;
         end else if (ERR_CLR) begin
            r_ovr <= 1'b0;
         end

         if (w_to_set) begin
            r_to <= 1'b1;
         end else if (ERR_CLR) begin
            r_to <= 1'b0;
         end
      end
   end

   assign REQ_VALID    = (r_state == ST_ISSUE) && r_en[r_slot];
   assign REQ_VOICE    = r_slot;
   assign SAMPLE_OUT   = r_sample;
   assign SAMPLE_VALID = (r_state == ST_DONE);
   assign BUSY         = (r_state != ST_IDLE);
   assign OVERRUN      = r_ovr;
   assign TIMEOUT_ERR  = r_to;

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Frame sequencer for the synth's shared voice datapath.
- On each 44.1 kHz sample tick, walks the enabled voice slots in order and issues one request per voice to the single shared oscillator/envelope datapath. It then sums the signed responses and presents one saturated mixed sample per tick.
- Runs entirely in the CLK_50MHZ domain. The CLK_44100HZ pulse from the oscillator divider is treated as an asynchronous input.

Parameters:
- NUM_VOICES, 8, number of voice slots; must be ≥2.
- DATA_W, 16, width of the signed voice response and of the mixed sample.
- TIMEOUT, 255, maximum cycles to wait for a response before the voice is forced to 0.

Ports:
- CLK_50MHZ  in  1  system clock.
- RESET_N  in  1  synchronous, active-low reset.
- CLK_44100HZ  in  1  sample tick, asynchronous to CLK_50MHZ.
- VOICE_EN  in  NUM_VOICES  per-slot enable, sampled at frame start.
- REQ_VALID  out  1  request to the datapath.
- REQ_VOICE  out  clog2(NUM_VOICES)  slot index of the request.
- REQ_READY  in  1  datapath accepts the request.
- RESP_VALID  in  1  datapath result strobe.
- RESP_DATA  in  DATA_W  signed voice sample.
- SAMPLE_OUT  out  DATA_W  signed mixed sample.
- SAMPLE_VALID  out  1  one-cycle strobe when SAMPLE_OUT updates.
- BUSY  out  1  a frame is in progress.
- OVERRUN  out  1  sticky: a tick arrived while BUSY.
- TIMEOUT_ERR  out  1  sticky: at least one response timed out.
- ERR_CLR  in  1  clears OVERRUN and TIMEOUT_ERR.

Behaviour:
- Reset (RESET_N=0 at a clock edge) sets all outputs to 0, FSM to IDLE, and clears the sync flops, accumulator, latched enables and timeout counter. Reset mid-frame abandons the frame with no SAMPLE_VALID.
- Tick detection: CLK_44100HZ passes through a 2-flop synchronizer, followed by a rising-edge detect. The resulting tick is one cycle wide, 3 cycles after the input rises.
- FSM states: IDLE, ISSUE, WAIT, SUM, DONE.
- IDLE, on tick:
  - latch VOICE_EN into en_q, clear accumulator, set slot=0, BUSY=1, go to ISSUE.
  - If en_q will be all zero, go directly to DONE; the output is 0.
- ISSUE:
  - If en_q[slot]=0, skip: advance slot, or go to DONE if this was the last slot; REQ_VALID stays 0.
  - Else drive REQ_VALID=1 and REQ_VOICE=slot. Hold both stable until REQ_READY=1.
  - On the REQ_VALID&&REQ_READY cycle, go to WAIT and clear the timeout counter. REQ_VALID drops the following cycle.
- WAIT:
  - On RESP_VALID, capture RESP_DATA and go to SUM.
  - If the counter reaches TIMEOUT, capture 0, set TIMEOUT_ERR, go to SUM.
  - RESP_VALID outside WAIT is ignored. A response in the same cycle as the timeout wins.
- SUM:
  - acc += sign-extended value; acc width is DATA_W+clog2(NUM_VOICES), so there is no internal overflow.
  - Advance slot and return to ISSUE, or go to DONE after slot NUM_VOICES-1.
- DONE:
  - SAMPLE_OUT = acc saturated to DATA_W: clamp to +2^(DATA_W-1)-1 / -2^(DATA_W-1).
  - SAMPLE_VALID=1 for exactly this cycle; BUSY=0 next cycle; go to IDLE.
- SAMPLE_OUT holds its value between frames.
- Overrun: a tick seen in any state other than IDLE sets OVERRUN. The tick is dropped, not queued, and the current frame continues.
- A tick in the same cycle as DONE also counts as overrun. The next frame starts only from IDLE.
- ERR_CLR clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- VOICE_EN changes mid-frame have no effect until the next tick.
- Minimum frame latency, tick to SAMPLE_VALID, with k enabled voices and single-cycle ready/response: 3k + skipped slots + 2 cycles.

Decomposition:
- Shared package (synth_pkg): FSM state encoding; DATA_W default; helper constant for the saturation limits.
- One natural sub-module: tick_sync (2-flop synchronizer plus rising-edge detect, output one-cycle pulse). Reusable for other cross-domain strobes.

Test Plan:
- Basic mix: NUM_VOICES=4, VOICE_EN=4'b1111, responder returns 100, 200, -50, 25 with single-cycle ready/response. Pulse the tick → REQ_VOICE sequence 0, 1, 2, 3; SAMPLE_OUT=275; one SAMPLE_VALID; BUSY low afterwards.
- Skip and empty: VOICE_EN=4'b0101 → requests only for slots 0 and 2. VOICE_EN=0 → SAMPLE_VALID with SAMPLE_OUT=0 and no REQ_VALID.
- Saturation: 4 voices each return 16'sh7000 → SAMPLE_OUT=16'sh7FFF. Each returns 16'sh9000 → 16'sh8000.
- Backpressure/timeout: hold REQ_READY low for 10 cycles → REQ_VALID/REQ_VOICE stable throughout. Never assert RESP_VALID for slot 1 → after 255 cycles slot 1 contributes 0, TIMEOUT_ERR=1, and the frame completes.
- Overrun: a second tick while BUSY → OVERRUN=1 and exactly one SAMPLE_VALID. ERR_CLR pulse → OVERRUN=0. A tick together with ERR_CLR → OVERRUN stays 1.
- Reset mid-frame: RESET_N low during WAIT → all outputs 0 and no SAMPLE_VALID. The next tick runs a clean frame with correct sum.
